vec_mm_sequencer: RTL and testbench

- Controller for the memory-to-memory vector datapath.
- Takes a single start command with base addresses for operands A, B and destination D, an element count and an op code.
- Walks the vector one 64-bit element at a time: reads A[i], reads B[i], computes, writes D[i].
- Sits between the command/issue logic and the single-port 64-bit data memory, and owns the operand latches and the element ALU.

---
 rtl/vec_mm_sequencer.sv | 131 +++++++++++++
 tb/tb_vec_mm_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_mm_sequencer.sv
// Memory-to-memory vector sequencer: for each element reads A[i] and B[i], applies
// the captured op, and writes D[i] through one single-port synchronous-read memory.
module vec_mm_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  input  logic [LEN_W-1:0]  vlen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  elem_idx
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] EXEC = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_d_q;
  logic [LEN_W-1:0]  vlen_q;
  logic [LEN_W-1:0]  idx_q;
  logic [63:0]       opa;
  logic [63:0]       opb;
  logic [63:0]       alu;
  logic [ADDR_W-1:0] idx_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_q     <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_d_q <= '0;
      vlen_q   <= '0;
      idx_q    <= '0;
      opa      <= '0;
      opb      <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx_q <= '0;
          if (start) begin
            op_q     <= op;
            base_a_q <= base_a;
            base_b_q <= base_b;
            base_d_q <= base_d;
            vlen_q   <= vlen;
            state    <= (vlen != '0) ? RD_A : DONE;
          end
        end
        RD_A: state <= RD_B;
        RD_B: begin
          opa   <= mem_rdata;
          state <= EXEC;
        end
        EXEC: begin
          opb   <= mem_rdata;
          state <= WR;
        end
        WR: begin
          if (idx_q == vlen_q - LEN_W'(1)) begin
            state <= DONE;
          end else begin
            idx_q <= idx_q + LEN_W'(1);
            state <= RD_A;
          end
        end
        DONE: begin
          idx_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu = '0;
    case (op_q)
      2'b00: alu = opa + opb;
      2'b01: alu = opa - opb;
      2'b10: alu = opa & opb;
      2'b11: alu = opa ^ opb;
      default: alu = '0;
    endcase
  end

  // Memory strobes are decoded from state so an async reset silences them at once.
  assign idx_a = ADDR_W'(idx_q);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      RD_A: mem_addr = base_a_q + idx_a;
      RD_B: mem_addr = base_b_q + idx_a;
      WR: begin
        mem_addr  = base_d_q + idx_a;
        mem_we    = 1'b1;
        mem_wdata = alu;
      end
      default: begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
      end
    endcase
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign elem_idx = idx_q;

endmodule

// File: tb/tb_vec_mm_sequencer.sv
// Bench for vec_mm_sequencer: synchronous-read memory model, write scoreboard,
// table of single-element ops and hand-built multi-cycle corner cases.
module tb_vec_mm_sequencer;
  localparam int AW = 10;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [AW-1:0] base_a = '0;
  logic [AW-1:0] base_b = '0;
  logic [AW-1:0] base_d = '0;
  logic [LW-1:0] vlen = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] elem_idx;

  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [63:0]   ld_data = '0;

  logic [63:0] mem    [0:1023];
  logic [63:0] shadow [0:1023];

  typedef struct { logic [AW-1:0] addr; logic [63:0] data; } wr_t;
  wr_t sb[$];

  typedef struct { string name; logic [1:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] exp; } vec_t;
  vec_t tbl[5];

  int n_checks = 0;
  int n_fail   = 0;

  vec_mm_sequencer #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .base_a(base_a), .base_b(base_b), .base_d(base_d), .vlen(vlen),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .elem_idx(elem_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    case (o)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic put(input logic [AW-1:0] a, input logic [63:0] d);
    shadow[a] = d;
    ld_addr = a;
    ld_data = d;
    ld_we = 1'b1;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic push_job(input logic [1:0] o, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                          input logic [AW-1:0] bd, input logic [LW-1:0] vl);
    logic [AW-1:0] aa, ab, ad;
    logic [63:0] r;
    for (int i = 0; i < int'(vl); i++) begin
      aa = ba + AW'(i);
      ab = bb + AW'(i);
      ad = bd + AW'(i);
      r = model(o, shadow[aa], shadow[ab]);
      shadow[ad] = r;
      sb.push_back('{ad, r});
    end
  endtask

  task automatic observe(input string tag, input int c, inout int n_we);
    wr_t w;
    if (mem_we === 1'b1) begin
      n_we++;
      check({tag, "_we_cycle"}, 64'(c), 64'(4 * n_we));
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s_sb: write addr %h data %h, required no write", tag, mem_addr, mem_wdata);
      end else begin
        w = sb.pop_front();
        check({tag, "_waddr"}, 64'(mem_addr), 64'(w.addr));
        check({tag, "_wdata"}, mem_wdata, w.data);
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                       input logic [AW-1:0] bd, input logic [LW-1:0] vl);
    @(negedge clk);
    op = o; base_a = ba; base_b = bb; base_d = bd; vlen = vl; start = 1'b1;
    @(negedge clk);
    // scramble command inputs: the DUT must use its captured copy
    start = 1'b0; op = ~o; base_a = ~ba; base_b = ~bb; base_d = ~bd; vlen = vl + 8'd3;
  endtask

  task automatic run_job(input string tag, input logic [1:0] o, input logic [AW-1:0] ba,
                         input logic [AW-1:0] bb, input logic [AW-1:0] bd,
                         input logic [LW-1:0] vl, input bit poke);
    int exp_done, n_we, done_at, n_done, busy_err;
    exp_done = 4 * int'(vl) + 1;
    n_we = 0; done_at = -1; n_done = 0; busy_err = 0;
    push_job(o, ba, bb, bd, vl);
    issue(o, ba, bb, bd, vl);
    for (int c = 1; c <= exp_done + 3; c++) begin
      observe(tag, c, n_we);
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (busy !== (c <= exp_done)) busy_err++;
      start = poke && (c == 2 || c == exp_done);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_at), 64'(exp_done));
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    check({tag, "_writes"}, 64'(n_we), 64'(vl));
    check({tag, "_busy_errs"}, 64'(busy_err), 64'd0);
    check({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int err, n_we;

    tbl[0] = '{"sub", 2'b01, 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F, 64'hF1EFF1EFF1EFF1F0};
    tbl[1] = '{"and", 2'b10, 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F, 64'h000F000F000F000F};
    tbl[2] = '{"xor", 2'b11, 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F, 64'h0FF00FF00FF00FF0};
    tbl[3] = '{"add_carry", 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1};
    tbl[4] = '{"sub_borrow", 2'b01, 64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF};

    // reset, then idle quiet
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    check("rst_idx", 64'(elem_idx), 64'd0);
    rst_n = 1'b1;
    err = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) err++;
    end
    check("idle_quiet", 64'(err), 64'd0);

    // add, vlen=3
    put(10'h010, 64'd1); put(10'h011, 64'd2); put(10'h012, 64'hFFFFFFFFFFFFFFFF);
    put(10'h020, 64'd10); put(10'h021, 64'd20); put(10'h022, 64'd1);
    run_job("add3", 2'b00, 10'h010, 10'h020, 10'h030, 8'd3, 1'b0);
    check("add3_d0", mem[10'h030], 64'd11);
    check("add3_d1", mem[10'h031], 64'd22);
    check("add3_d2", mem[10'h032], 64'd0);

    // single-element op table
    for (int i = 0; i < 5; i++) begin
      put(10'h050, tbl[i].a);
      put(10'h060, tbl[i].b);
      put(10'h070, 64'h0);
      run_job(tbl[i].name, tbl[i].op, 10'h050, 10'h060, 10'h070, 8'd1, 1'b0);
      check({tbl[i].name, "_mem"}, mem[10'h070], tbl[i].exp);
    end

    // vlen=0, then start pokes during a vlen=4 job and in its DONE cycle
    run_job("vlen0", 2'b00, 10'h080, 10'h090, 10'h0A0, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      put(AW'(10'h080 + i), {$urandom, $urandom});
      put(AW'(10'h090 + i), {$urandom, $urandom});
    end
    run_job("poke4", 2'b01, 10'h080, 10'h090, 10'h0A0, 8'd4, 1'b1);

    // address wrap with in-place destination
    put(10'h3FF, 64'h1000); put(10'h000, 64'h7);
    put(10'h100, 64'h0234); put(10'h101, 64'hFFFFFFFFFFFFFFFF);
    run_job("wrap", 2'b00, 10'h3FF, 10'h100, 10'h3FF, 8'd2, 1'b0);
    check("wrap_3ff", mem[10'h3FF], 64'h1234);
    check("wrap_000", mem[10'h000], 64'h6);

    // reset during element 2 EXEC
    for (int i = 0; i < 4; i++) begin
      put(AW'(10'h200 + i), 64'(100 * (i + 1)));
      put(AW'(10'h210 + i), 64'(i + 1));
      put(AW'(10'h220 + i), 64'hDEAD_0000_0000_0000 + 64'(i));
    end
    push_job(2'b00, 10'h200, 10'h210, 10'h220, 8'd4);
    issue(2'b00, 10'h200, 10'h210, 10'h220, 8'd4);
    n_we = 0;
    for (int c = 1; c <= 11; c++) begin
      observe("midrst", c, n_we);
      if (c < 11) @(negedge clk);
    end
    check("midrst_idx", 64'(elem_idx), 64'd2);
    check("midrst_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_idx0", 64'(elem_idx), 64'd0);
    check("midrst_writes", 64'(n_we), 64'd2);
    sb.delete();
    shadow[10'h222] = 64'hDEAD_0000_0000_0002;
    shadow[10'h223] = 64'hDEAD_0000_0000_0003;
    repeat (3) @(negedge clk);
    check("midrst_d0", mem[10'h220], 64'd101);
    check("midrst_d1", mem[10'h221], 64'd202);
    check("midrst_d2", mem[10'h222], 64'hDEAD_0000_0000_0002);
    check("midrst_d3", mem[10'h223], 64'hDEAD_0000_0000_0003);
    rst_n = 1'b1;
    run_job("after_rst", 2'b11, 10'h200, 10'h210, 10'h220, 8'd4, 1'b0);
    check("after_rst_d3", mem[10'h223], 64'd400 ^ 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
